// File: rtl/apb_multi_accum_if.sv
// APB bus bundle for apb_multi_accum.
// Master drives request fields; slave returns data, ready and error.
interface apb_multi_accum_if #(
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [7:0]        PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multi_accum.sv
// NUM_CH-channel APB accumulator slave with programmable wait states.
// Optional irq output enabled by defining APB_ACC_IRQ_EN.
module apb_multi_accum #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic PCLK,
  input  logic PRESETn,
`ifdef APB_ACC_IRQ_EN
  apb_multi_accum_if.slave apb,
  output logic irq
`else
  apb_multi_accum_if.slave apb
`endif
);

  typedef enum logic [1:0] {
    IDLE, SETUP, WAIT, ACCESS
  } state_e;

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  state_e state_q, state_d, phase;
  logic [2:0] wcnt_q, wcnt_d;

  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] data_d [NUM_CH];
  logic [DATA_W-1:0] res_q  [NUM_CH];
  logic [DATA_W-1:0] res_d  [NUM_CH];
  logic [1:0]        op_q   [NUM_CH];
  logic [1:0]        op_d   [NUM_CH];
  logic              ie_q   [NUM_CH];
  logic              ie_d   [NUM_CH];
  logic              auto_q [NUM_CH];
  logic              auto_d [NUM_CH];
  logic              ovf_q  [NUM_CH];
  logic              ovf_d  [NUM_CH];
  logic [7:0]        cnt_q  [NUM_CH];
  logic [7:0]        cnt_d  [NUM_CH];

  logic [3:0]        ch;
  logic [1:0]        rsel;
  logic              err;
  logic              commit;
  logic [DATA_W-1:0] operand;
  logic              do_op;
  logic [DATA_W:0]   acc_r;
  logic [DATA_W-1:0] rdata;

  function automatic logic [DATA_W:0] acc_f(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0] r;
    unique case (op)
      2'b00:   r = {1'b0, a | b};
      2'b01:   r = {1'b0, a & b};
      2'b10:   r = {1'b0, a ^ b};
      default: r = {1'b0, a} + {1'b0, b};
    endcase
    return r;
  endfunction

  assign ch   = apb.PADDR[7:4];
  assign rsel = apb.PADDR[3:2];
  assign err  = (|apb.PADDR[1:0])
              | ({1'b0, ch} >= 5'(NUM_CH))
              | (apb.PWRITE & rsel[1]);

  // Phase of the current cycle; setup is recognised from the bus itself
  always_comb begin
    phase = state_q;
    if (!PRESETn || !apb.PSEL) phase = IDLE;
    else if (!apb.PENABLE)     phase = SETUP;
  end

  always_comb begin
    state_d = IDLE;
    wcnt_d  = wcnt_q;
    unique case (phase)
      SETUP: begin
        wcnt_d  = '0;
        state_d = (WC == 3'd0) ? ACCESS : WAIT;
      end
      WAIT: begin
        wcnt_d  = wcnt_q + 3'd1;
        state_d = (wcnt_q + 3'd1 == WC) ? ACCESS : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = (phase == ACCESS) & apb.PWRITE & ~err;

  always_comb begin
    operand = '0;
    do_op   = 1'b0;
    acc_r   = '0;
    data_d  = data_q;
    res_d   = res_q;
    op_d    = op_q;
    ie_d    = ie_q;
    auto_d  = auto_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      operand = data_q[c];
      do_op   = 1'b0;
      acc_r   = '0;
      if (commit && ch == 4'(c)) begin
        if (rsel == 2'd0) begin
          data_d[c] = apb.PWDATA;
          operand   = apb.PWDATA;
          do_op     = auto_q[c];
        end else begin
          op_d[c]   = apb.PWDATA[3:2];
`ifdef APB_ACC_IRQ_EN
          ie_d[c]   = apb.PWDATA[4];
`else
          ie_d[c]   = 1'b0;
`endif
          auto_d[c] = apb.PWDATA[5];
          if (apb.PWDATA[1]) begin
            res_d[c] = '0;
            ovf_d[c] = 1'b0;
            cnt_d[c] = '0;
          end else begin
            do_op = apb.PWDATA[0];
          end
        end
        if (do_op) begin
          acc_r    = acc_f(op_d[c], res_q[c], operand);
          res_d[c] = acc_r[DATA_W-1:0];
          if (op_d[c] == 2'b11 && acc_r[DATA_W]) ovf_d[c] = 1'b1;
          if (cnt_q[c] != 8'hFF) cnt_d[c] = cnt_q[c] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 4'(c)) begin
        unique case (rsel)
          2'd0: rdata = data_q[c];
          2'd1: rdata = DATA_W'({auto_q[c], ie_q[c],
                                 op_q[c], 2'b00});
          2'd2: rdata = res_q[c];
          default: rdata = DATA_W'({cnt_q[c], 7'd0, ovf_q[c]});
        endcase
      end
    end
  end

  assign apb.PREADY  = (phase == ACCESS);
  assign apb.PSLVERR = (phase == ACCESS) & err;
  assign apb.PRDATA  = (phase == ACCESS && !apb.PWRITE && !err)
                     ? rdata : '0;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= '0;
        res_q[c]  <= '0;
        op_q[c]   <= '0;
        ie_q[c]   <= 1'b0;
        auto_q[c] <= 1'b0;
        ovf_q[c]  <= 1'b0;
        cnt_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      res_q   <= res_d;
      op_q    <= op_d;
      ie_q    <= ie_d;
      auto_q  <= auto_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef APB_ACC_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq_d = irq_d | (ovf_q[c] & ie_q[c]);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule
